// File: rtl/led_blinker_multi_if.sv
// led_blinker_multi_if
//   Bundles the configuration inputs and LED outputs of led_blinker_multi.
//   master: board-control side (drives enable/rate/mode, observes outputs)
//   slave : the blinker itself
// Signals:
//   i_enable     global enable, low forces every channel idle
//   i_rate       2 bits per channel, channel c at [2c+1:2c]
//   i_mode       2 bits per channel: 00 off, 01 steady, 10 blink, 11 burst
//   o_led_drive  registered LED drive, bit c = channel c
//   o_burst_done one-cycle pulse at the end of each burst window
interface led_blinker_multi_if #(
  parameter int N_CH = 4
);
  logic                i_enable;
  logic [2*N_CH-1:0]   i_rate;
  logic [2*N_CH-1:0]   i_mode;
  logic [N_CH-1:0]     o_led_drive;
  logic [N_CH-1:0]     o_burst_done;

  modport master (
    output i_enable,
    output i_rate,
    output i_mode,
    input  o_led_drive,
    input  o_burst_done
  );

  modport slave (
    input  i_enable,
    input  i_rate,
    input  i_mode,
    output o_led_drive,
    output o_burst_done
  );
endinterface

// File: rtl/led_blinker_multi.sv
// led_blinker_multi
//   N_CH independent LED drivers on one clock. Each channel holds its last
//   seen rate/mode and restarts from phase zero whenever that configuration
//   changes, whenever enable is low, and on the edge where enable rises.
// Ports:
//   i_clock  system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      led_blinker_multi_if slave modport (enable, rate, mode in;
//            led drive and burst-done pulses out)
module led_blinker_multi #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 24,
  parameter int C100      = 125000,
  parameter int C50       = 250000,
  parameter int C10       = 1250000,
  parameter int C1        = 12500000,
  parameter int BURST_LEN = 3
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  led_blinker_multi_if.slave   bus
);

  // k runs 0..4*BURST_LEN-1: first half is the burst window, second the gap.
  localparam int            KW     = $clog2(4 * BURST_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(4 * BURST_LEN - 1);
  localparam logic [KW-1:0] K_GAP  = KW'(2 * BURST_LEN);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  // Previous enable, so the edge where enable rises is treated as a restart.
  logic en_q;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= bus.i_enable;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [1:0]       rate_in, mode_in;
      logic [1:0]       rate_q, mode_q;
      logic [CNT_W-1:0] cnt_q, cnt_d, half_m1;
      logic [KW-1:0]    k_q, k_d;
      logic             led_q, led_d;
      logic             done_q, done_d;
      logic             restart, wrap;

      assign rate_in = bus.i_rate[2*gi +: 2];
      assign mode_in = bus.i_mode[2*gi +: 2];

      // Terminal count for the held rate; outside a restart cycle the held
      // rate equals the input rate, so this is the active half-period.
      always_comb begin
        case (rate_q)
          2'b00:   half_m1 = CNT_W'(C100 - 1);
          2'b01:   half_m1 = CNT_W'(C50 - 1);
          2'b10:   half_m1 = CNT_W'(C10 - 1);
          default: half_m1 = CNT_W'(C1 - 1);
        endcase
      end

      always_comb begin
        restart = !bus.i_enable || !en_q || (rate_in != rate_q) || (mode_in != mode_q);
        wrap    = (cnt_q == half_m1);
        cnt_d   = cnt_q;
        k_d     = k_q;
        led_d   = 1'b0;
        done_d  = 1'b0;
        if (restart) begin
          // Enable low wins over everything, so steady-on only lights when enabled.
          cnt_d = '0;
          k_d   = '0;
          led_d = bus.i_enable && (mode_in == 2'b01);
        end else begin
          case (mode_q)
            2'b00: begin
              cnt_d = '0;
              k_d   = '0;
            end
            2'b01: begin
              cnt_d = '0;
              k_d   = '0;
              led_d = 1'b1;
            end
            2'b10: begin
              if (wrap) begin
                cnt_d = '0;
                k_d   = (k_q == K_ONE) ? '0 : K_ONE;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
              led_d = (k_d == K_ONE);
            end
            default: begin
              if (wrap) begin
                cnt_d  = '0;
                k_d    = (k_q == K_LAST) ? '0 : k_q + K_ONE;
                // Only an advance can land on the gap start, so this is one cycle.
                done_d = (k_d == K_GAP);
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
              led_d = (k_d < K_GAP) && k_d[0];
            end
          endcase
        end
      end

      always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
          rate_q <= 2'b00;
          mode_q <= 2'b00;
          cnt_q  <= '0;
          k_q    <= '0;
          led_q  <= 1'b0;
          done_q <= 1'b0;
        end else begin
          // Held cfg always tracks the input; a difference is what flags a restart.
          rate_q <= rate_in;
          mode_q <= mode_in;
          cnt_q  <= cnt_d;
          k_q    <= k_d;
          led_q  <= led_d;
          done_q <= done_d;
        end
      end

      assign bus.o_led_drive[gi]  = led_q;
      assign bus.o_burst_done[gi] = done_q;
    end
  endgenerate

endmodule

// File: doc/led_blinker_multi.md
# led_blinker_multi

Multi-channel successor to the single-output LED blinker: N_CH independent LED drivers share one clock. Each channel has its own rate select (100/50/10/1 Hz class) and mode (off, steady, blink, burst). Channels restart from a defined phase whenever their configuration changes. The block sits between the board-control register/switch logic and the LED pins, one output per LED.

## Interface

Parameters:
- N_CH, 4, number of LED channels (≥1)
- CNT_W, 24, half-period counter width; C1 < 2^CNT_W required
- C100, 125000, half-period in clocks for rate 00
- C50, 250000, half-period in clocks for rate 01
- C10, 1250000, half-period in clocks for rate 10
- C1, 12500000, half-period in clocks for rate 11
- BURST_LEN, 3, high pulses per burst window (≥1)

Ports:
- i_clock  in  1  system clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  global enable; low forces all channels idle
- i_rate  in  2*N_CH  per-channel rate select, channel c at [2c+1:2c]
- i_mode  in  2*N_CH  per-channel mode, channel c at [2c+1:2c]: 00 off, 01 steady on, 10 blink, 11 burst
- o_led_drive  out  N_CH  registered LED drive, bit c = channel c
- o_burst_done  out  N_CH  one-cycle pulse at the end of each burst window

## Operation

- Per-channel state: held cfg (rate, mode), half-period counter cnt (CNT_W bits), half-period index k (0..4*BURST_LEN-1), and output register.
- Half-period H = C100/C50/C10/C1 for rate 00/01/10/11.
- Restart, in any cycle where the channel's i_rate/i_mode differ from held cfg, or i_enable is low: load cfg, cnt=0, k=0, o_led_drive[c]=0, except mode 01 with enable high, where o_led_drive[c]=1.
- Otherwise cnt increments each cycle; when cnt==H-1, cnt→0 and k advances (k wraps at 2 in blink mode and at 4*BURST_LEN in burst mode).
- Mode 00: output 0, counters held at 0.
- Mode 01: output 1 while enabled, counters held at 0.
- Mode 10: output = (k==1); 50% duty, period 2H, first half-period low.
- Mode 11: burst window k=0..2*BURST_LEN-1, output high on odd k; gap k=2*BURST_LEN..4*BURST_LEN-1, output low. o_burst_done[c] is high for the single cycle in which k becomes 2*BURST_LEN; it is 0 in all other modes.
- Channels are fully independent. No channel's config or timing affects another.

## Timing

- Reset: i_rst_n low asynchronously clears all cfg, cnt, k, o_led_drive=0, o_burst_done=0. First restart evaluation occurs at the first rising edge after release.
- All outputs are registered. A config change sampled at edge T takes effect on output at edge T (restart values visible after T).
- Blink after restart at edge T0: output rises at edge T0+H, falls at T0+2H, and repeats with period 2H.
- Config change mid-period (including mid-high): output drops at that edge; there is no completion of the old half-period.
- i_enable low overrides everything, including a simultaneous config change: output 0 at the next edge. Rising enable acts as a restart at that edge.
- Rate change within the same mode is also a restart.
- H=1 is legal: the output toggles every cycle in blink mode.

## Test plan

Bench parameters: N_CH=2, C100=10, C50=20, C10=50, C1=100, BURST_LEN=2.
- Reset: assert i_rst_n low mid-blink between edges → o_led_drive=00 and o_burst_done=00 immediately, held while low; after release with blink cfg, first rise occurs 10 cycles after the first restart edge.
- Blink: ch0 mode 10 rate 00, ch1 mode 10 rate 11, enable=1 → ch0 high cycles 10–19, 30–39…; ch1 high cycles 100–199, 300–399…; channels are independent.
- Rate change: ch0 switches rate 00→01 at cycle 15 (output high) → output 0 from cycle 15, high 35–54, 75–94, period 40.
- Burst: ch0 mode 11 rate 00 restarted at cycle 0 → high 10–19 and 30–39, low 40–79, o_burst_done[0] pulse at cycle 40 only, pattern repeats from cycle 80.
- Enable drop: i_enable low for cycles 23–27 during blink → outputs 0 from cycle 23; on re-enable at cycle 28, ch0 rises at 38 with period 20.
- Steady/off plus conflict: ch1 mode 01 → output 1 at the next edge; ch0 mode 00 → output 0. Config change coincident with enable fall → both outputs 0 and no burst_done pulse.
